temp_bcd_conv: RTL and testbench

//  Converts a signed DS18B20-format temperature word (two's complement, LSB = 1/16 degC) into four

---
 rtl/temp_bcd_conv.sv | 160 ++++++++++++++++
 tb/tb_temp_bcd_conv.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/temp_bcd_conv.sv
// temp_bcd_conv
//   Converts a signed DS18B20-format temperature word (two's complement,
//   1/16 degC per LSB) into four display nibbles for seg_disp. The integer
//   part and the tenths digit are first packed into one binary value. That
//   value is then turned into BCD by an iterative double-dabble, one bit per
//   cycle. A one-deep pending slot holds a sample that arrives while a
//   conversion is running.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   temp_raw  signed temperature, 1/16 degC per LSB
//   temp_vld  1-cycle strobe qualifying temp_raw
//   dout      {digit3, digit2, digit1, digit0} to seg_disp din
//   dout_vld  4'hF for one cycle when dout updates, else 4'h0
//   busy      high while in LOAD/CONV/DONE
module temp_bcd_conv #(
    parameter logic [3:0]         SIGN_CODE  = 4'hA,
    parameter logic [3:0]         BLANK_CODE = 4'hB,
    parameter logic [3:0]         ERR_CODE   = 4'hE,
    parameter logic signed [15:0] TEMP_MAX   = 16'sd2015,
    parameter logic signed [15:0] TEMP_MIN   = -16'sd880
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] temp_raw,
    input  logic        temp_vld,
    output logic [15:0] dout,
    output logic [3:0]  dout_vld,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, LOAD, CONV, DONE} state_t;

    state_t      state, state_nxt;

    logic [15:0] raw_q;      // sample being converted
    logic        neg_q;
    logic        err_q;
    logic [10:0] bin_q;      // binary tenths, shifted out MSB first
    logic [15:0] bcd_q;      // {th, hu, te, un}
    logic [3:0]  cnt_q;
    logic        pend_vld;
    logic [15:0] pend_data;

    // A new sample can be taken on leaving IDLE or DONE. In DONE a coincident
    // strobe wins over the pending slot.
    logic        take_new;
    logic        take_pend;

    // LOAD-stage arithmetic on the captured sample.
    logic [15:0] mag;
    logic [7:0]  frac10;
    logic [3:0]  tenths;
    logic [10:0] bin_ld;
    logic        out_of_range;

    // Double-dabble step.
    logic [15:0] bcd_adj;
    logic [15:0] bcd_step;

    logic [3:0]  digit3;

    assign busy      = (state != IDLE);
    assign take_new  = temp_vld && (state == IDLE || state == DONE);
    assign take_pend = (state == DONE) && !temp_vld && pend_vld;

    always_comb begin
        mag          = raw_q[15] ? 16'(-raw_q) : raw_q;
        frac10       = {4'b0, mag[3:0]} * 8'd10;
        tenths       = frac10[7:4];
        bin_ld       = 11'(mag[10:4]) * 11'd10 + 11'(tenths);
        out_of_range = ($signed(raw_q) > TEMP_MAX) || ($signed(raw_q) < TEMP_MIN);
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
        bcd_step = {bcd_adj[14:0], bin_q[10]};
    end

    always_comb begin
        if (bcd_q[15:12] == 4'd1) digit3 = 4'h1;
        else if (neg_q)           digit3 = SIGN_CODE;
        else                      digit3 = BLANK_CODE;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (temp_vld) state_nxt = LOAD;
            LOAD: state_nxt = out_of_range ? DONE : CONV;
            CONV: if (cnt_q == 4'd0) state_nxt = DONE;
            DONE: state_nxt = (temp_vld || pend_vld) ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q     <= '0;
            neg_q     <= 1'b0;
            err_q     <= 1'b0;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            pend_vld  <= 1'b0;
            pend_data <= '0;
            dout      <= '0;
            dout_vld  <= '0;
        end else begin
            dout_vld <= 4'h0;

            if (take_new)       raw_q <= temp_raw;
            else if (take_pend) raw_q <= pend_data;

            // The pending slot is filled during LOAD/CONV and is emptied when
            // DONE starts the next conversion. A coincident strobe in DONE
            // also drops it.
            if (state == DONE) begin
                pend_vld <= 1'b0;
            end else if (temp_vld && state != IDLE) begin
                pend_vld  <= 1'b1;
                pend_data <= temp_raw;
            end

            case (state)
                LOAD: begin
                    neg_q <= raw_q[15];
                    err_q <= out_of_range;
                    bin_q <= bin_ld;
                    bcd_q <= '0;
                    cnt_q <= 4'd10;
                end
                CONV: begin
                    bcd_q <= bcd_step;
                    bin_q <= {bin_q[9:0], 1'b0};
                    cnt_q <= cnt_q - 4'd1;
                end
                DONE: begin
                    dout     <= err_q ? {4{ERR_CODE}} : {digit3, bcd_q[11:0]};
                    dout_vld <= 4'hF;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_bcd_conv.sv
module tb_temp_bcd_conv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] temp_raw = '0;
    logic        temp_vld = 1'b0;
    logic [15:0] dout;
    logic [3:0]  dout_vld;
    logic        busy;

    int n_run = 0;
    int n_fail = 0;

    temp_bcd_conv dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .temp_raw (temp_raw),
        .temp_vld (temp_vld),
        .dout     (dout),
        .dout_vld (dout_vld),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drive a one-cycle strobe. The task returns on the negedge right after
    // the accepting posedge.
    task automatic strobe(input logic [15:0] r);
        @(negedge clk);
        temp_raw = r;
        temp_vld = 1'b1;
        @(negedge clk);
        temp_vld = 1'b0;
    endtask

    // Count the clocks until dout_vld is seen, up to a bounded number.
    task automatic wait_vld(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (dout_vld == 4'hF) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic single(input string tag, input logic [15:0] r,
                          input logic [15:0] exp, input int exp_lat);
        int lat;
        strobe(r);
        wait_vld(lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_dout"}, dout, exp);
        @(negedge clk);
        chk({tag, "_vld1cyc"}, dout_vld, 4'h0);
        chk({tag, "_hold"}, dout, exp);
        repeat (2) @(negedge clk);
    endtask

    // Watch a window of clocks. Record the count of pulses and the first two
    // dout values.
    task automatic watch(input int cycles, output int n,
                         output logic [15:0] v0, output logic [15:0] v1);
        n = 0; v0 = '0; v1 = '0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (dout_vld != 4'h0) begin
                if (n == 0) v0 = dout;
                else if (n == 1) v1 = dout;
                n++;
            end
        end
    endtask

    initial begin
        int n, lat;
        logic [15:0] v0, v1;

        #1;
        chk("rst_dout", dout, 16'h0000);
        chk("rst_vld", dout_vld, 4'h0);
        chk("rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        single("t1_25", 16'h0191, 16'hB250, 13);
        single("t2_125", 16'h07D0, 16'h1250, 13);
        single("t2_m55", 16'hFC90, 16'hA550, 13);
        single("t2_m10", 16'hFF5E, 16'hA101, 13);
        single("t3_126", 16'h07E0, 16'hEEEE, 2);
        single("t3_m56", 16'hFC80, 16'hEEEE, 2);
        single("t3_max", 16'h07DF, 16'h1259, 13);
        single("negzero", 16'hFFFF, 16'hA000, 13);
        chk("idle_busy", busy, 1'b0);

        // Two strobes during CONV: only the latest one is converted.
        strobe(16'h0191);
        chk("t4_busy", busy, 1'b1);
        strobe(16'h0050);
        strobe(16'h00A0);
        watch(60, n, v0, v1);
        chk("t4_npulse", n, 2);
        chk("t4_first", v0, 16'hB250);
        chk("t4_second", v1, 16'hB100);

        // Reset in the middle of CONV.
        strobe(16'h0191);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_dout", dout, 16'h0000);
        chk("t5_vld", dout_vld, 4'h0);
        chk("t5_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        watch(20, n, v0, v1);
        chk("t5_nopulse", n, 0);
        single("t5_zero", 16'h0000, 16'hB000, 13);

        // A strobe in the DONE cycle replaces the older pending sample.
        strobe(16'h0191);              // k=0 here
        repeat (2) @(negedge clk);      // k=2
        temp_raw = 16'h0050;
        temp_vld = 1'b1;
        @(negedge clk);                 // k=3
        temp_vld = 1'b0;
        repeat (9) @(negedge clk);      // k=12, DONE
        chk("t6_done_busy", busy, 1'b1);
        temp_raw = 16'h00A0;
        temp_vld = 1'b1;
        @(negedge clk);                 // k=13
        temp_vld = 1'b0;
        chk("t6_vldA", dout_vld, 4'hF);
        chk("t6_doutA", dout, 16'hB250);
        wait_vld(lat);
        chk("t6_lat", lat, 13);
        chk("t6_doutC", dout, 16'hB100);
        watch(30, n, v0, v1);
        chk("t6_noextra", n, 0);
        chk("t6_busy_end", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
